// File: rtl/disp_pkg.sv
// ============================================================================
// Module   : disp_pkg
// Brief    : Shared types and helpers for the display scheduler.
// Revision : 1.0
// ============================================================================
`default_nettype none

package disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    OWN  = 2'd2
  } state_t;

  localparam int         NREQ       = 3;
  localparam logic [3:0] IDLE_DIGIT = 4'hF;

  // Isolates the lowest set bit, i.e. the highest-priority requester.
  function automatic logic [NREQ-1:0] prio_onehot(input logic [NREQ-1:0] v);
    return v & (~v + NREQ'(1));
  endfunction

endpackage

`default_nettype wire

// File: rtl/tick_gen.sv
// ============================================================================
// Module   : tick_gen
// Brief    : Free-running divider; one-cycle tick every TICK_DIV clocks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic ck,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (r_cnt == C_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tick = (r_cnt == C_LAST);

endmodule

`default_nettype wire

// File: rtl/display_sched.sv
// ============================================================================
// Module   : display_sched
// Brief    : Fixed-priority time-sharing of the 7-segment display controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module display_sched
  import disp_pkg::*;
#(
  parameter int TICK_DIV   = 50000,
  parameter int HOLD_TICKS = 200
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic [2:0]  req,
  input  logic [15:0] val0,
  input  logic [15:0] val1,
  input  logic [15:0] val2,
  input  logic [2:0]  bin,
  output logic [2:0]  gnt,
  output logic        busy,
  output logic [3:0]  x3,
  output logic [3:0]  x2,
  output logic [3:0]  x1,
  output logic [3:0]  x0,
  output logic        sel
);

  localparam int            HW            = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;
  localparam logic [HW-1:0] C_HOLD        = HW'(HOLD_TICKS);
  localparam state_t        C_GRANT_STATE = (HOLD_TICKS == 0) ? OWN : HOLD;
  localparam logic [15:0]   C_IDLE_DIGITS = {4{IDLE_DIGIT}};

  state_t          r_state, w_state;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic [HW-1:0]   r_hold, w_hold;
  logic [15:0]     r_digits, w_digits;
  logic            r_sel, w_sel;
  logic            r_busy;

  logic            w_tick;
  logic [NREQ-1:0] w_win;
  logic [15:0]     w_win_val, w_own_val;
  logic            w_win_bin, w_own_bin, w_own_req;
  logic            w_decide, w_new_grant, w_track, w_release;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .ck    (ck),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  assign w_win     = prio_onehot(req);
  assign w_win_val = ({16{w_win[0]}} & val0) | ({16{w_win[1]}} & val1) | ({16{w_win[2]}} & val2);
  assign w_win_bin = |(w_win & bin);
  assign w_own_val = ({16{r_gnt[0]}} & val0) | ({16{r_gnt[1]}} & val1) | ({16{r_gnt[2]}} & val2);
  assign w_own_bin = |(r_gnt & bin);
  assign w_own_req = |(r_gnt & req);

  always_comb begin
    w_state     = r_state;
    w_gnt       = r_gnt;
    w_hold      = r_hold;
    w_digits    = r_digits;
    w_sel       = r_sel;
    w_decide    = 1'b0;
    w_new_grant = 1'b0;
    w_track     = 1'b0;
    w_release   = 1'b0;

    case (r_state)
      IDLE: w_new_grant = |req;
      HOLD: begin
        if (w_tick && (r_hold == HW'(1))) begin
          w_decide = 1'b1;
        end else begin
          w_track = w_own_req;
          if (w_tick) w_hold = r_hold - HW'(1);
        end
      end
      OWN:     w_decide  = 1'b1;
      default: w_release = 1'b1;
    endcase

    // A winner other than the owner is either higher priority or the owner has let go.
    if (w_decide) begin
      if ((|req) && (w_win != r_gnt)) begin
        w_new_grant = 1'b1;
      end else if (|req) begin
        w_track = 1'b1;
        w_state = OWN;
      end else begin
        w_release = 1'b1;
      end
    end

    if (w_new_grant) begin
      w_state  = C_GRANT_STATE;
      w_gnt    = w_win;
      w_hold   = C_HOLD;
      w_digits = w_win_val;
      w_sel    = w_win_bin;
    end else if (w_track) begin
      w_digits = w_own_val;
      w_sel    = w_own_bin;
    end else if (w_release) begin
      w_state  = IDLE;
      w_gnt    = '0;
      w_hold   = '0;
      w_digits = C_IDLE_DIGITS;
      w_sel    = 1'b0;
    end
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_hold   <= '0;
      r_digits <= C_IDLE_DIGITS;
      r_sel    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_gnt    <= w_gnt;
      r_hold   <= w_hold;
      r_digits <= w_digits;
      r_sel    <= w_sel;
      r_busy   <= |w_gnt;
    end
  end

  assign gnt  = r_gnt;
  assign busy = r_busy;
  assign x3   = r_digits[15:12];
  assign x2   = r_digits[11:8];
  assign x1   = r_digits[7:4];
  assign x0   = r_digits[3:0];
  assign sel  = r_sel;

endmodule

`default_nettype wire
